// File: rtl/sram_fifo_ctrl_if.sv
// Handshake and SRAM bus bundle for sram_fifo_ctrl.
//   in_valid/in_ready/in_data     : upstream word stream into the FIFO
//   out_valid/out_ready/out_data  : downstream word stream out of the FIFO
//   sram_cs_n/sram_wr_n/sram_addr/sram_wdata/sram_rdata : single-port SRAM
//   count/full                    : occupancy status
// The slave modport is the controller view; the master modport is the
// environment (upstream, downstream and SRAM macro) view.
interface sram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 6
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    sram_cs_n;
    logic                    sram_wr_n;
    logic [ADDR_WIDTH-1:0]   sram_addr;
    logic [DATA_WIDTH-1:0]   sram_wdata;
    logic [DATA_WIDTH-1:0]   sram_rdata;
    logic [ADDR_WIDTH+1:0]   count;
    logic                    full;

    modport slave (
        input  in_valid, in_data, out_ready, sram_rdata,
        output in_ready, out_valid, out_data,
        output sram_cs_n, sram_wr_n, sram_addr, sram_wdata,
        output count, full
    );

    modport master (
        output in_valid, in_data, out_ready, sram_rdata,
        input  in_ready, out_valid, out_data,
        input  sram_cs_n, sram_wr_n, sram_addr, sram_wdata,
        input  count, full
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller built around a single-port SRAM with registered read data,
// followed by a two-entry output buffer that decouples the SRAM read latency
// from the downstream handshake.
// Ports:
//   inst_clk   : sole clock, rising edge
//   inst_rst_n : asynchronous active-low reset
//   bus        : sram_fifo_ctrl_if.slave (handshakes, SRAM bus, count/full)
// At most one SRAM access happens per cycle. Reads are issued only when the
// output buffer is guaranteed room for the returning word, and take priority
// over writes only when the output side would otherwise starve.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic              inst_clk,
    input  logic              inst_rst_n,
    sram_fifo_ctrl_if.slave   bus
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   sram_cnt_q, sram_cnt_d;
    logic [1:0]            obuf_cnt_q, obuf_cnt_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [DATA_WIDTH-1:0] obuf0_q, obuf0_d;
    logic [DATA_WIDTH-1:0] obuf1_q, obuf1_d;

    logic       full;
    logic       pop;
    logic [1:0] obuf_post;
    logic       rd_ok;
    logic       starve;
    logic       rd_issue;
    logic       in_ready;
    logic       wr_en;

    always_comb begin
        full      = (sram_cnt_q == DEPTH_C);
        pop       = (obuf_cnt_q != 2'd0) && bus.out_ready;
        obuf_post = obuf_cnt_q - {1'b0, pop};
        // A word already in flight will land in the buffer, so it counts
        // against the room available for a new read.
        rd_ok     = (sram_cnt_q != '0) &&
                    ((obuf_post + {1'b0, rd_inflight_q}) < 2'd2);
        // Starvation is judged after this cycle's pop; using the pre-pop
        // occupancy would let writes win every other slot and drop the
        // steady-state rate to one word per three cycles.
        starve    = (obuf_post == 2'd0) && !rd_inflight_q;
        rd_issue  = rd_ok && (starve || !(bus.in_valid && !full));
        in_ready  = inst_rst_n && !full && !rd_issue;
        wr_en     = bus.in_valid && in_ready;
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        sram_cnt_d    = sram_cnt_q;
        rd_inflight_d = rd_issue;
        obuf0_d       = obuf0_q;
        obuf1_d       = obuf1_q;
        obuf_cnt_d    = obuf_post + {1'b0, rd_inflight_q};

        if (wr_en) begin
            wr_ptr_d   = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
            sram_cnt_d = sram_cnt_q + 1'b1;
        end else if (rd_issue) begin
            rd_ptr_d   = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
            sram_cnt_d = sram_cnt_q - 1'b1;
        end

        if (pop) begin
            obuf0_d = obuf1_q;
        end

        // sram_rdata is only meaningful the cycle after a read; the returning
        // word goes to the first free slot after any pop, which keeps order.
        if (rd_inflight_q) begin
            if (obuf_post == 2'd0) begin
                obuf0_d = bus.sram_rdata;
            end else begin
                obuf1_d = bus.sram_rdata;
            end
        end
    end

    always_ff @(posedge inst_clk or negedge inst_rst_n) begin
        if (!inst_rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            sram_cnt_q    <= '0;
            obuf_cnt_q    <= 2'd0;
            rd_inflight_q <= 1'b0;
            obuf0_q       <= '0;
            obuf1_q       <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            sram_cnt_q    <= sram_cnt_d;
            obuf_cnt_q    <= obuf_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            obuf0_q       <= obuf0_d;
            obuf1_q       <= obuf1_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.full       = full;
    assign bus.out_valid  = (obuf_cnt_q != 2'd0);
    assign bus.out_data   = obuf0_q;
    assign bus.sram_cs_n  = !(wr_en || rd_issue);
    assign bus.sram_wr_n  = !wr_en;
    assign bus.sram_addr  = wr_en ? wr_ptr_q : (rd_issue ? rd_ptr_q : '0);
    assign bus.sram_wdata = bus.in_data;
    assign bus.count      = (ADDR_WIDTH+2)'(sram_cnt_q)
                          + (ADDR_WIDTH+2)'(obuf_cnt_q)
                          + (ADDR_WIDTH+2)'(rd_inflight_q);

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
module tb_sram_fifo_ctrl;

    localparam int DW = 32;
    localparam int DP = 64;
    localparam int AW = 6;

    logic clk;
    logic rst_n;

    sram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW)) dut (
        .inst_clk   (clk),
        .inst_rst_n (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro model: synchronous write, registered read data that holds
    // its last value when no read is performed.
    logic [DW-1:0] mem [DP];
    always @(posedge clk) begin
        if (!bus.sram_cs_n) begin
            if (!bus.sram_wr_n) mem[bus.sram_addr] <= bus.sram_wdata;
            else                bus.sram_rdata     <= mem[bus.sram_addr];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input bit ok,
                                input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic void eq(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        chk(name, act === exp, act, exp);
    endfunction

    // Scoreboard and SRAM address model, sampled on the falling edge.
    logic [DW-1:0] sb [$];
    int            exp_wa = 0;
    int            exp_ra = 0;
    int            n_pop  = 0;
    bit            hold_prev = 0;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_wa    = 0;
            exp_ra    = 0;
            hold_prev = 0;
        end else begin
            if (hold_prev) begin
                eq("hold_valid", 32'(bus.out_valid), 32'd1);
                eq("hold_data", bus.out_data, prev_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("pop_empty", 1'b0, bus.out_data, 32'd0);
                end else begin
                    eq("order", bus.out_data, sb[0]);
                    void'(sb.pop_front());
                end
                n_pop++;
            end
            if (bus.in_valid && bus.in_ready) begin
                eq("wr_cs_n", 32'(bus.sram_cs_n), 32'd0);
                eq("wr_wr_n", 32'(bus.sram_wr_n), 32'd0);
                eq("wr_addr", 32'(bus.sram_addr), 32'(exp_wa));
                eq("wr_wdata", bus.sram_wdata, bus.in_data);
                sb.push_back(bus.in_data);
                exp_wa = (exp_wa + 1) % DP;
            end else if (!bus.sram_cs_n) begin
                eq("rd_wr_n", 32'(bus.sram_wr_n), 32'd1);
                eq("rd_addr", 32'(bus.sram_addr), 32'(exp_ra));
                exp_ra = (exp_ra + 1) % DP;
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
        end
    end

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [31:0] e_cnt;
        logic        e_cs;
        logic        e_wr;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl [12];

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic push(input logic [31:0] d);
        bit ok;
        ok           = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (!ok) chk("push_timeout", 1'b0, d, d);
    endtask

    task automatic wait_empty(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus.count == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, ok, 32'(bus.count), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int p0;
        int d;
        bit ok;

        tbl[0]  = '{1'b1, 32'hA5, 1'b1, 1'b1, 1'b0, 32'h0,  32'd0, 1'b0, 1'b0, 32'd0};
        tbl[1]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  32'd1, 1'b0, 1'b1, 32'd0};
        tbl[2]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  32'd1, 1'b1, 1'b1, 32'd0};
        tbl[3]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA5, 32'd1, 1'b1, 1'b1, 32'd0};
        tbl[4]  = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 32'h0,  32'd0, 1'b0, 1'b0, 32'd1};
        tbl[5]  = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 32'h0,  32'd1, 1'b0, 1'b1, 32'd1};
        tbl[6]  = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 32'h0,  32'd1, 1'b0, 1'b0, 32'd2};
        tbl[7]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h11, 32'd2, 1'b0, 1'b1, 32'd2};
        tbl[8]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h11, 32'd2, 1'b1, 1'b1, 32'd0};
        tbl[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h11, 32'd2, 1'b1, 1'b1, 32'd0};
        tbl[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h22, 32'd1, 1'b1, 1'b1, 32'd0};
        tbl[11] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  32'd0, 1'b1, 1'b1, 32'd0};

        // Reset values, with in_valid held high to show in_ready is forced low.
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hFFFF;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        eq("rst_out_data", bus.out_data, 32'd0);
        eq("rst_count", 32'(bus.count), 32'd0);
        eq("rst_full", 32'(bus.full), 32'd0);
        eq("rst_cs_n", 32'(bus.sram_cs_n), 32'd1);
        eq("rst_wr_n", 32'(bus.sram_wr_n), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Cycle-by-cycle directed vectors starting at reset release.
        for (int i = 0; i < 12; i++) begin
            bus.in_valid  = tbl[i].iv;
            bus.in_data   = tbl[i].id;
            bus.out_ready = tbl[i].ordy;
            @(negedge clk);
            eq($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_ir));
            eq($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov)
                eq($sformatf("v%0d_out_data", i), bus.out_data, tbl[i].e_od);
            eq($sformatf("v%0d_count", i), 32'(bus.count), tbl[i].e_cnt);
            eq($sformatf("v%0d_cs_n", i), 32'(bus.sram_cs_n), 32'(tbl[i].e_cs));
            eq($sformatf("v%0d_wr_n", i), 32'(bus.sram_wr_n), 32'(tbl[i].e_wr));
            eq($sformatf("v%0d_addr", i), 32'(bus.sram_addr), tbl[i].e_addr);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Fill to capacity with the output stalled, then drain through the
        // pointer wrap.
        do_reset();
        for (int i = 0; i < 66; i++) push(32'(i));
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD;
        repeat (4) @(negedge clk);
        eq("fill_count", 32'(bus.count), 32'd66);
        eq("fill_full", 32'(bus.full), 32'd1);
        eq("fill_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        p0            = n_pop;
        bus.out_ready = 1'b1;
        wait_empty("fill_drain");
        eq("fill_drained_words", 32'(n_pop - p0), 32'd66);
        eq("fill_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Random traffic on both sides with downstream backpressure.
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = $urandom;
            bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_empty("bp_drain");
        repeat (2) @(posedge clk);
        #1;

        // Both sides continuously active: steady state is one word per two
        // cycles, first word out after three cycles.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        p0            = n_pop;
        for (int i = 0; i < 200; i++) begin
            bus.in_data = $urandom;
            @(posedge clk); #1;
        end
        d = n_pop - p0;
        chk("throughput", (d >= 98) && (d <= 100), 32'(d), 32'd99);
        bus.in_valid = 1'b0;
        wait_empty("tp_drain");
        bus.out_ready = 1'b0;

        // Reset while a read is in flight and a word is buffered; the stale
        // SRAM output must not reappear afterwards.
        do_reset();
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(i));
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        eq("pre_rst_count", 32'(bus.count), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        eq("mid_rst_out_data", bus.out_data, 32'd0);
        eq("mid_rst_count", 32'(bus.count), 32'd0);
        eq("mid_rst_full", 32'(bus.full), 32'd0);
        eq("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        eq("mid_rst_cs_n", 32'(bus.sram_cs_n), 32'd1);
        eq("mid_rst_wr_n", 32'(bus.sram_wr_n), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        push(32'h3C);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("post_rst_valid", ok, 32'(bus.out_valid), 32'd1);
        if (ok) eq("post_rst_data", bus.out_data, 32'h3C);
        @(posedge clk); #1;
        wait_empty("post_rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
